// File: rtl/fp_serial_mantissa_rounder.sv
// Serial mantissa capture and round-to-nearest-even stage.
// Takes an MSB-first frame of MANT_W mantissa bits followed by guard, round
// and sticky. It rounds the frame and presents a registered result with a
// one-cycle valid pulse. Latency from start to valid is MANT_W+4 cycles.
module fp_serial_mantissa_rounder #(
  parameter int unsigned MANT_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_in_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [MANT_W-1:0] mant_out_o,
  output logic              carry_out_o,
  output logic              inexact_o
);

  localparam int unsigned FrameW = MANT_W + 3;
  localparam int unsigned CntW   = $clog2(FrameW + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic                carry_q, carry_d;
  logic                inexact_q, inexact_d;
  logic                valid_q, valid_d;

  // Rounding datapath, decoded from the complete frame register.
  logic [MANT_W-1:0]   frame_mant;
  logic                guard_bit, round_bit, sticky_bit;
  logic                round_up;
  logic [MANT_W:0]     round_sum;

  // Round-to-nearest-even: a tie (G=1, R=S=0) only rounds up when M is odd.
  always_comb begin
    frame_mant = frame_q[FrameW-1:3];
    guard_bit  = frame_q[2];
    round_bit  = frame_q[1];
    sticky_bit = frame_q[0];
    round_up   = guard_bit & (round_bit | sticky_bit | frame_mant[0]);
    round_sum  = {1'b0, frame_mant} + {{MANT_W{1'b0}}, round_up};
  end

  // Next-state logic for the frame FSM, the bit counter and the result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    mant_d    = mant_q;
    carry_d   = carry_q;
    inexact_d = inexact_q;
    valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // After FrameW-1 further shifts this bit lands in the MSB.
          frame_d = {{(FrameW-1){1'b0}}, s_in_i};
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end

      StShift: begin
        frame_d = {frame_q[FrameW-2:0], s_in_i};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(FrameW - 1)) begin
          state_d = StRound;
        end
      end

      StRound: begin
        if (round_sum[MANT_W]) begin
          // Mantissa overflowed: renormalise to 1.000... and flag exponent +1.
          mant_d  = {1'b1, {(MANT_W-1){1'b0}}};
          carry_d = 1'b1;
        end else begin
          mant_d  = round_sum[MANT_W-1:0];
          carry_d = 1'b0;
        end
        inexact_d = guard_bit | round_bit | sticky_bit;
        valid_d   = 1'b1;
        cnt_d     = '0;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and result registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      frame_q   <= '0;
      mant_q    <= '0;
      carry_q   <= 1'b0;
      inexact_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      mant_q    <= mant_d;
      carry_q   <= carry_d;
      inexact_q <= inexact_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs come straight from registered state; no input-to-output path.
  always_comb begin
    busy_o      = (state_q != StIdle);
    valid_o     = valid_q;
    mant_out_o  = mant_q;
    carry_out_o = carry_q;
    inexact_o   = inexact_q;
  end

endmodule

// File: tb/tb_fp_serial_mantissa_rounder.sv
// Bench for fp_serial_mantissa_rounder: table vectors plus corner sequences,
// with a scoreboard queue checked whenever the DUT raises valid.
module tb_fp_serial_mantissa_rounder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        s_in_i = 1'b0;
  logic        busy_o;
  logic        valid_o;
  logic [23:0] mant_out_o;
  logic        carry_out_o;
  logic        inexact_o;

  fp_serial_mantissa_rounder #(.MANT_W(24)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .s_in_i     (s_in_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .mant_out_o (mant_out_o),
    .carry_out_o(carry_out_o),
    .inexact_o  (inexact_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] m;
    logic [2:0]  grs;
    logic [23:0] em;
    logic        ec;
    logic        ei;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [23:0] m;
    logic        c;
    logic        i;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [23:0] held_m = '0;
  logic        held_c = 1'b0;
  logic        held_i = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: round to nearest even on a 24-bit mantissa.
  function automatic logic [25:0] model(input logic [23:0] m, input logic [2:0] grs);
    logic        up;
    logic [23:0] mm;
    up = grs[2] & (grs[1] | grs[0] | m[0]);
    if (up && m == 24'hFFFFFF) return {1'b1, 24'h800000, 1'b1};
    mm = m + 24'(up);
    return {1'b0, mm, |grs};
  endfunction

  // Scoreboard monitor: every valid must match the oldest expectation and arrive
  // on its cycle; outside valid the outputs must hold.
  always @(negedge clk_i) begin
    if (rst_i) begin
      held_m <= '0;
      held_c <= 1'b0;
      held_i <= 1'b0;
    end else if (valid_o) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("mant_out", 32'(mant_out_o), 32'(e.m));
        chk("carry_out", 32'(carry_out_o), 32'(e.c));
        chk("inexact", 32'(inexact_o), 32'(e.i));
        held_m <= mant_out_o;
        held_c <= carry_out_o;
        held_i <= inexact_o;
      end
    end else begin
      chk("hold_mant", 32'(mant_out_o), 32'(held_m));
      chk("hold_flags", {30'd0, carry_out_o, inexact_o}, {30'd0, held_c, held_i});
    end
  end

  // Drives one frame plus the ROUND cycle; the next call starts on the valid cycle.
  task automatic send(input logic [23:0] m, input logic [2:0] grs, input logic [23:0] em,
                      input logic ec, input logic ei, input int inj_a, input int inj_b,
                      input int abort_at);
    logic [26:0] f;
    int          c0;
    exp_t        e;
    f  = {m, grs};
    c0 = 0;
    for (int i = 0; i < 28; i++) begin
      @(posedge clk_i);
      #1;
      chk("busy", 32'(busy_o), 32'(i != 0));
      if (i == 0) c0 = cyc;
      start_i = (i < 27) && ((i == 0) || (i == inj_a) || (i == inj_b));
      s_in_i  = (i < 27) ? f[26-i] : 1'($urandom);
      if (i == abort_at) begin
        #1 rst_i = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_mant", 32'(mant_out_o), 32'd0);
        chk("rst_flags", {30'd0, carry_out_o, inexact_o}, 32'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        return;
      end
    end
    e.cyc = c0 + 28;
    e.m   = em;
    e.c   = ec;
    e.i   = ei;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      s_in_i  = 1'($urandom);
      chk("idle_busy", 32'(busy_o), 32'd0);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [25:0] r;
    logic [23:0] rm;
    logic [2:0]  rg;
    int          waited;

    vecs[0]  = '{24'hC00001, 3'b000, 24'hC00001, 1'b0, 1'b0};
    vecs[1]  = '{24'hC00000, 3'b100, 24'hC00000, 1'b0, 1'b1};
    vecs[2]  = '{24'hC00001, 3'b100, 24'hC00002, 1'b0, 1'b1};
    vecs[3]  = '{24'hA00000, 3'b101, 24'hA00001, 1'b0, 1'b1};
    vecs[4]  = '{24'hA00000, 3'b011, 24'hA00000, 1'b0, 1'b1};
    vecs[5]  = '{24'hFFFFFF, 3'b110, 24'h800000, 1'b1, 1'b1};
    vecs[6]  = '{24'h7FFFFF, 3'b100, 24'h800000, 1'b0, 1'b1};
    vecs[7]  = '{24'hFFFFFF, 3'b100, 24'h800000, 1'b1, 1'b1};
    vecs[8]  = '{24'hFFFFFE, 3'b100, 24'hFFFFFE, 1'b0, 1'b1};
    vecs[9]  = '{24'h000001, 3'b111, 24'h000002, 1'b0, 1'b1};
    vecs[10] = '{24'h123456, 3'b010, 24'h123456, 1'b0, 1'b1};
    vecs[11] = '{24'h800000, 3'b000, 24'h800000, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_mant", 32'(mant_out_o), 32'd0);
    chk("reset_flags", {30'd0, carry_out_o, inexact_o}, 32'd0);
    rst_i = 1'b0;
    idle(2);

    // Table vectors, back to back: each start lands on the previous valid cycle.
    for (int k = 0; k < 12; k++) begin
      send(vecs[k].m, vecs[k].grs, vecs[k].em, vecs[k].ec, vecs[k].ei, -1, -1, -1);
    end

    // Stray starts at cycles 5 and 20 must not restart the frame.
    send(24'hC00001, 3'b100, 24'hC00002, 1'b0, 1'b1, 5, 20, -1);
    idle(3);

    // Random frames against the reference model.
    for (int k = 0; k < 6; k++) begin
      rm = 24'($urandom);
      rg = 3'($urandom_range(0, 7));
      if (k == 0) rm[0] = 1'b1;
      r  = model(rm, rg);
      send(rm, rg, r[24:1], r[25], r[0], -1, -1, -1);
    end
    idle(2);

    // Reset in cycle 13 of a frame: no valid may follow, then a clean frame.
    send(24'hABCDEF, 3'b111, 24'h0, 1'b0, 1'b0, -1, -1, 13);
    idle(35);
    send(24'hA00000, 3'b101, 24'hA00001, 1'b0, 1'b1, -1, -1, -1);

    waited = 0;
    while (q.size() != 0 && waited < 60) begin
      @(posedge clk_i);
      waited++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_serial_mantissa_rounder.md
# fp_serial_mantissa_rounder

Serial-in mantissa capture and round-to-nearest-even stage for the floating-point datapath. It consumes the same MSB-first serial stream that feeds the 27-bit serial mantissa register: 24 mantissa bits followed by guard, round and sticky. It counts the frame, rounds it, and presents a registered 24-bit rounded mantissa with carry and inexact flags and a one-cycle valid pulse. It sits directly downstream of the serial shifter and upstream of exponent adjust and pack.

## Interface
- `MANT_W`, default 24: mantissa width including the hidden bit. Frame length is `MANT_W+3`, i.e. 27 at the default.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: frame start. It is sampled together with the first (MSB) serial bit.
- `s_in` input, 1 bit: serial data, MSB first, one bit per cycle.
- `busy` output, 1 bit: high while a frame is being shifted or rounded.
- `valid` output, 1 bit: one-cycle pulse when the result outputs update.
- `mant_out` output, `MANT_W` bits: rounded mantissa, held until the next valid.
- `carry_out` output, 1 bit: rounding overflowed the mantissa, so exponent +1 is required.
- `inexact` output, 1 bit: the OR of guard, round and sticky for the frame.

## Operation
- The block has one clock, `clk`. Reset is asynchronous and active-high on `rst`.
- States are IDLE, SHIFT and ROUND.
- **IDLE**
  - `start`=1 captures `s_in` as frame bit 26 (MSB), sets the bit counter to 1 and moves to SHIFT.
  - `start`=0 keeps the block in IDLE.
- **SHIFT**
  - Each cycle shifts `s_in` into the LSB of the internal 27-bit frame register and increments the counter.
  - When the counter reaches 27 bits received, the state moves to ROUND.
  - `start` is ignored in SHIFT. A new frame cannot restart an in-flight one.
- **ROUND**
  - The frame is split as M = frame[26:3], G = frame[2], R = frame[1], S = frame[0].
  - The round-up condition is up = G & (R | S | M[0]). This is nearest-even: an exact tie (G=1, R=S=0) rounds up only when M is odd.
  - The sum is {1'b0,M} + up, 25 bits wide.
  - If sum[24]=1 then `carry_out`=1 and `mant_out`={1'b1, 23'b0}, which is the renormalised value. Otherwise `carry_out`=0 and `mant_out`=sum[23:0].
  - `inexact` = G|R|S.
  - All result outputs are registered at the end of ROUND. `valid`=1 in the following cycle and the state returns to IDLE.
- `start` in the cycle where `valid`=1 (IDLE) is accepted. This gives back-to-back frames with no gap.
- `s_in` is don't-care outside SHIFT and outside the start cycle.
- **Reset values:**
  - state = IDLE, counter = 0, frame register = 0.
  - `busy`=0, `valid`=0, `mant_out`=0, `carry_out`=0, `inexact`=0.
- **Reset mid-frame:** the partial frame is discarded. No `valid` is produced and outputs return to their reset values.

## Timing
- Cycle 0: `start`=1 and bit 26 is on `s_in`. Cycles 1..26 carry bits 25..0.
- Cycle 27: ROUND.
- Cycle 28: `valid`=1 with new outputs. Latency from start to valid is 28 cycles.
- `busy`=1 from cycle 1 through cycle 27 and 0 in cycle 28. It reflects registered state.
- `valid` is high for exactly one cycle per accepted frame.
- `mant_out`, `carry_out` and `inexact` change only on the valid cycle or on reset.
- Maximum throughput is one frame per 28 cycles.
- All flops use asynchronous `rst`. Nothing is combinational from input to output.

## Test plan
- **Exact value:** M=0xC00001, GRS=000 → at cycle 28 `mant_out`=0xC00001, `carry_out`=0, `inexact`=0, `valid` pulse of width 1.
- **Ties:**
  - M=0xC00000, GRS=100 (even tie) → `mant_out`=0xC00000, `inexact`=1.
  - M=0xC00001, GRS=100 (odd tie) → `mant_out`=0xC00002.
- **Above half:** M=0xA00000, GRS=101 → `mant_out`=0xA00001. M=0xA00000, GRS=011 → 0xA00000 with `inexact`=1.
- **Overflow:** M=0xFFFFFF, GRS=110 → `carry_out`=1, `mant_out`=0x800000, `inexact`=1.
- **Busy and back-to-back:**
  - Pulse `start` at cycles 5 and 20 of a frame → both ignored, a single result arrives at cycle 28.
  - `start` on the valid cycle → second result arrives 28 cycles later, and the first frame's outputs hold until then.
- **Reset mid-frame:** assert `rst` asynchronously at cycle 13 → `busy`, `valid` and all outputs go to 0 immediately. No valid pulse follows, and a fresh frame afterwards rounds correctly.
